// File: rtl/instruction_cache.sv
// Instruction cache: DEPTH x 32-bit word store with a zero-latency combinational
// read port and a clocked program-load write port. Out-of-range reads return
// NOP_WORD; misaligned or out-of-range loads are dropped.
// Optional feature macro ICACHE_PARITY_EN adds a per-word even-parity bit and a
// parity_err flag on the read port; without it parity_err is tied low.
module instruction_cache #(
   parameter int unsigned DEPTH    = 256,
   parameter logic [31:0] NOP_WORD = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] address_input,
   output logic [31:0] data_output,
   output logic        misaligned,
   output logic        out_of_range,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        parity_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [31:0]      mem [DEPTH];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] ld_idx;
   logic             ld_ok;

   // Upper address bits above the word index flag out-of-range instead of aliasing
   assign rd_idx       = address_input[IDX_W+1:2];
   assign misaligned   = |address_input[1:0];
   assign out_of_range = (address_input >> (IDX_W + 2)) != 32'd0;
   assign data_output  = out_of_range ? NOP_WORD : mem[rd_idx];

   assign ld_idx = load_addr[IDX_W+1:2];
   assign ld_ok  = load_en && (load_addr[1:0] == 2'b00) &&
                   ((load_addr >> (IDX_W + 2)) == 32'd0);

   // Word store: reset fills every word with NOP_WORD, qualified loads write one word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= NOP_WORD;
         end
      end else if (ld_ok) begin
         mem[ld_idx] <= load_data;
      end
   end

`ifdef ICACHE_PARITY_EN
   // Even parity: the stored bit makes the total count of ones (word + bit) even
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

   logic par [DEPTH];

   // Parity store tracks the word store so reset and loads stay consistent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            par[i] <= even_parity(NOP_WORD);
         end
      end else if (ld_ok) begin
         par[ld_idx] <= even_parity(load_data);
      end
   end

   assign parity_err = !out_of_range && (even_parity(mem[rd_idx]) != par[rd_idx]);
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios followed by
// randomized reads and loads compared against a word-array reference model.
`timescale 1ns/1ps
module tb_instruction_cache;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] NOP   = 32'h00000013;
   localparam logic [31:0] LIMIT = DEPTH * 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] address_input;
   logic [31:0] data_output;
   logic        misaligned;
   logic        out_of_range;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;
   logic        parity_err;

   int n_tests;
   int n_fail;

   logic [31:0] ref_mem [DEPTH];

   instruction_cache #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .address_input(address_input),
      .data_output  (data_output),
      .misaligned   (misaligned),
      .out_of_range (out_of_range),
      .load_en      (load_en),
      .load_addr    (load_addr),
      .load_data    (load_data),
      .parity_err   (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic void ref_reset();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (a >= LIMIT) return NOP;
      return ref_mem[a / 4];
   endfunction

   function automatic void ref_load(input logic [31:0] a, input logic [31:0] d);
      if (a % 4 == 0 && a < LIMIT) ref_mem[a / 4] = d;
   endfunction

   // Compare every read-side output against the model for the current address
   task automatic check_read(input string tag);
      check({tag, "_data"}, data_output, ref_read(address_input));
      check({tag, "_mis"}, {31'd0, misaligned}, {31'd0, (address_input % 4) != 0});
      check({tag, "_oor"}, {31'd0, out_of_range}, {31'd0, address_input >= LIMIT});
      check({tag, "_par"}, {31'd0, parity_err}, 32'd0);
   endtask

   // One cycle: drive at negedge, check pre-edge, apply edge, check post-edge
   task automatic cycle(input logic [31:0] ra, input logic le, input logic [31:0] la,
                        input logic [31:0] ld, input string tag);
      @(negedge clk);
      address_input = ra;
      load_en       = le;
      load_addr     = la;
      load_data     = ld;
      #1;
      check_read({tag, "_pre"});
      @(posedge clk);
      if (le && rst_n) ref_load(la, ld);
      #1;
      check_read({tag, "_post"});
   endtask

   initial begin
      logic [31:0] ra, la, ld;
      logic        le;
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      address_input = 32'h0;
      load_en       = 1'b0;
      load_addr     = 32'h0;
      load_data     = 32'h0;
      ref_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset contents
      cycle(32'h04, 1'b0, 32'h0, 32'h0, "rst04");
      cycle(32'h0C, 1'b0, 32'h0, 32'h0, "rst0c");
      cycle(32'h20, 1'b0, 32'h0, 32'h0, "rst20");

      // Program loads and read-back
      cycle(32'h04, 1'b1, 32'h04, 32'h00500093, "ld04");
      cycle(32'h0C, 1'b1, 32'h0C, 32'h00A00113, "ld0c");
      cycle(32'h20, 1'b1, 32'h20, 32'h002081B3, "ld20");
      cycle(32'h04, 1'b0, 32'h0, 32'h0, "rd04");
      check("rd04_val", data_output, 32'h00500093);
      cycle(32'h06, 1'b0, 32'h0, 32'h0, "rd06");
      check("rd06_val", data_output, 32'h00500093);

      // Out-of-range read and ignored loads
      cycle(32'h400, 1'b1, 32'h400, 32'hCAFEF00D, "oor400");
      check("oor400_val", data_output, NOP);
      cycle(32'h00, 1'b1, 32'h02, 32'h12345678, "mis02");
      cycle(32'h00, 1'b1, 32'h1000, 32'h87654321, "alias1000");
      cycle(32'h403, 1'b0, 32'h0, 32'h0, "both");

      // Same-index read/load, then asynchronous reset mid-cycle
      cycle(32'h0C, 1'b1, 32'h0C, 32'hDEADBEEF, "hold0c");
      check("hold0c_val", data_output, 32'hDEADBEEF);
      @(negedge clk);
      load_en = 1'b0;
      #1 rst_n = 1'b0;
      ref_reset();
      #1;
      check_read("async_rst");
      check("async_rst_val", data_output, NOP);

      // Load attempted while reset is held is dropped
      load_en   = 1'b1;
      load_addr = 32'h10;
      load_data = 32'h11111111;
      @(posedge clk);
      #1;
      address_input = 32'h10;
      #1;
      check_read("rst_ld");
      @(negedge clk);
      load_en = 1'b0;
      rst_n   = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0:       ra = $urandom;
            1:       ra = la;
            default: ra = $urandom_range(0, LIMIT - 1);
         endcase
         le = $urandom_range(0, 1);
         case ($urandom_range(0, 9))
            0:       la = $urandom;
            1:       la = $urandom_range(0, LIMIT - 1);
            default: la = $urandom_range(0, 63) * 4;
         endcase
         ld = $urandom;
         cycle(ra, le, la, ld, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
